// File: rtl/jtag_master_if.sv
// Host-side request/response bundle for the JTAG scan master.
interface jtag_master_if #(
  parameter int MAX_LEN = 32
);
  logic               start;
  logic [1:0]         op;
  logic [4:0]         len;
  logic [MAX_LEN-1:0] data_in;
  logic               busy;
  logic               done;
  logic [MAX_LEN-1:0] data_out;

  modport master (
    output start, op, len, data_in,
    input  busy, done, data_out
  );

  modport slave (
    input  start, op, len, data_in,
    output busy, done, data_out
  );
endinterface

// File: rtl/jtag_master.sv
// JTAG scan master: runs DR/IR scans and the Test-Logic-Reset sequence,
// generating TCK from clk and driving TMS/TDI on TCK falling edges.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no operation; TCK/TMS/TDI held low
// PRE    | Select/Capture path (DR: 1,0,0  IR: 1,1,0,0  TLR: 1,1,1,1)
// SHIFT  | shift rises 0..N-1, TMS high on the last one
// POST   | Exit1/Update then Run-Test/Idle (TMS 1,0)
// FINISH | final rise done; next TCK fall completes the operation
//
// The state/step pair always describes the next TCK rise. It advances on
// each rise, and the following fall drives TMS/TDI for the new position.
module jtag_master #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic           clk,
  input  logic           TRST,
  jtag_master_if.slave   host,
  output logic           TCK,
  output logic           TMS,
  output logic           TDI,
  input  logic           TDO
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SHIFT,
    POST,
    FINISH
  } state_t;

  localparam logic [1:0] OP_DR  = 2'b00;
  localparam logic [1:0] OP_IR  = 2'b01;
  localparam logic [1:0] OP_TLR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  state_t             state;
  state_t             state_nxt;
  logic [4:0]         step;
  logic [4:0]         step_nxt;
  logic [7:0]         div_cnt;
  logic [1:0]         op_q;
  logic [4:0]         last_q;
  logic [MAX_LEN-1:0] din_q;
  logic [MAX_LEN-1:0] cap_q;
  logic [MAX_LEN-1:0] data_out_q;
  logic               done_q;
  logic               tms_nxt;
  logic [4:0]         pre_last;
  logic               accept;
  logic               tck_edge;
  logic               rise;
  logic               fall;

  assign accept   = (state == IDLE) && host.start && (host.op != OP_RSV);
  assign tck_edge = (state != IDLE) && (div_cnt == 8'd0);
  assign rise     = tck_edge && !TCK;
  assign fall     = tck_edge && TCK;
  // DR enters Shift after three rises; IR and TLR use four before SHIFT/POST
  assign pre_last = (op_q == OP_DR) ? 5'd2 : 5'd3;

  assign host.busy     = (state != IDLE);
  assign host.done     = done_q;
  assign host.data_out = data_out_q;

  // FSM state register and position counter
  always_ff @(posedge clk or negedge TRST) begin
    if (!TRST) begin
      state <= IDLE;
      step  <= 5'd0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  // Next-state on TCK rises (completion on the fall) and TMS for the next rise
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    tms_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = PRE;
          step_nxt  = 5'd0;
        end
      end
      PRE: begin
        unique case (op_q)
          OP_DR:   tms_nxt = (step == 5'd0);
          OP_IR:   tms_nxt = (step < 5'd2);
          default: tms_nxt = 1'b1;
        endcase
        if (rise) begin
          if (step == pre_last) begin
            state_nxt = (op_q == OP_TLR) ? POST : SHIFT;
            step_nxt  = 5'd0;
          end else begin
            step_nxt = step + 5'd1;
          end
        end
      end
      SHIFT: begin
        tms_nxt = (step == last_q);
        if (rise) begin
          if (step == last_q) begin
            state_nxt = POST;
            step_nxt  = 5'd0;
          end else begin
            step_nxt = step + 5'd1;
          end
        end
      end
      POST: begin
        tms_nxt = (step == 5'd0);
        if (rise) begin
          if (step == 5'd1) begin
            state_nxt = FINISH;
            step_nxt  = 5'd0;
          end else begin
            step_nxt = step + 5'd1;
          end
        end
      end
      FINISH: begin
        if (fall) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = 5'd0;
      end
    endcase
  end

  // TCK divider, pin drive on falls, TDO capture on shift rises, result latch
  always_ff @(posedge clk or negedge TRST) begin
    if (!TRST) begin
      TCK        <= 1'b0;
      TMS        <= 1'b0;
      TDI        <= 1'b0;
      div_cnt    <= 8'd0;
      op_q       <= OP_DR;
      last_q     <= 5'd0;
      din_q      <= '0;
      cap_q      <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // first rise of every sequence has TMS=1
        TCK     <= 1'b0;
        TMS     <= 1'b1;
        TDI     <= 1'b0;
        div_cnt <= DIV_LOAD;
        op_q    <= host.op;
        last_q  <= host.len - 5'd1;
        din_q   <= host.data_in;
        cap_q   <= '0;
      end else if (state != IDLE) begin
        if (tck_edge) begin
          TCK     <= ~TCK;
          div_cnt <= DIV_LOAD;
        end else begin
          div_cnt <= div_cnt - 8'd1;
        end
        if (rise && (state == SHIFT)) begin
          cap_q <= cap_q | (MAX_LEN'(TDO) << step);
          din_q <= din_q >> 1;
        end
        if (fall) begin
          if (state == FINISH) begin
            done_q <= 1'b1;
            TMS    <= 1'b0;
            TDI    <= 1'b0;
            if (op_q != OP_TLR) begin
              data_out_q <= cap_q;
            end
          end else begin
            TMS <= tms_nxt;
            TDI <= (state == SHIFT) && din_q[0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master: records TMS/TDI at every TCK rise and
// compares sequences, timing and captured data with hand-computed values.
module tb_jtag_master;
  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 32;

  logic clk = 1'b0;
  logic trst = 1'b0;
  logic tck, tms, tdi;
  logic tdo = 1'b0;

  jtag_master_if #(.MAX_LEN(MAX_LEN)) hif ();

  jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk  (clk),
    .TRST (trst),
    .host (hif.slave),
    .TCK  (tck),
    .TMS  (tms),
    .TDI  (tdi),
    .TDO  (tdo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [63:0] tms_bits, tdi_bits;
  int n_rise, busy_cyc, done_cnt, viol;
  logic done_busy, done_tck, done_tms, timeout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // tdo_mode: 0 tied low, 1 tied high, 2 TDI looped back delayed one TCK fall
  task automatic run_op(input logic [1:0] op_v, input logic [4:0] len_v,
                        input logic [31:0] din_v, input int tdo_mode,
                        input int pulse_at, input string tag);
    logic prev_tck, prev_tms, prev_tdi;
    tms_bits = '0; tdi_bits = '0;
    n_rise = 0; busy_cyc = 0; done_cnt = 0; viol = 0;
    timeout = 1'b1; done_busy = 1'b1; done_tck = 1'b1; done_tms = 1'b1;
    tdo = (tdo_mode == 1);
    hif.op = op_v; hif.len = len_v; hif.data_in = din_v; hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    check({tag, "_accept"}, 64'(hif.busy), 64'd1);
    prev_tck = 1'b0; prev_tms = 1'b0; prev_tdi = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c == pulse_at) begin
        hif.start = 1'b1; hif.op = 2'b01; hif.len = 5'd3; hif.data_in = '1;
      end else begin
        hif.start = 1'b0;
      end
      if (hif.busy) busy_cyc++;
      if (tck && !prev_tck && n_rise < 64) begin
        tms_bits[n_rise] = tms;
        tdi_bits[n_rise] = tdi;
        n_rise++;
      end
      if (c > 0 && !(prev_tck && !tck) && (tms !== prev_tms || tdi !== prev_tdi)) viol++;
      if (prev_tck && !tck && tdo_mode == 2) tdo = prev_tdi;
      if (hif.done) begin
        done_cnt++;
        done_busy = hif.busy; done_tck = tck; done_tms = tms;
        timeout = 1'b0;
        break;
      end
      prev_tck = tck; prev_tms = tms; prev_tdi = tdi;
      @(negedge clk);
    end
    hif.start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int exp_rise, input logic [63:0] exp_tms,
                           input logic [63:0] exp_tdi, input logic [31:0] exp_out);
    check({tag, "_timeout"},  64'(timeout), 64'd0);
    check({tag, "_rises"},    64'(n_rise), 64'(exp_rise));
    check({tag, "_tms"},      tms_bits, exp_tms);
    check({tag, "_tdi"},      tdi_bits, exp_tdi);
    check({tag, "_busy_cyc"}, 64'(busy_cyc), 64'(exp_rise * 2 * CLK_DIV));
    check({tag, "_done_st"},  {61'd0, done_busy, done_tck, done_tms}, 64'd0);
    check({tag, "_pin_edge"}, 64'(viol), 64'd0);
    check({tag, "_data_out"}, 64'(hif.data_out), 64'(exp_out));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    hif.start = 1'b0; hif.op = 2'b00; hif.len = 5'd0; hif.data_in = '0;
    trst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(hif.busy), 64'd0);
    check("rst_done", 64'(hif.done), 64'd0);
    check("rst_pins", {61'd0, tck, tms, tdi}, 64'd0);
    check("rst_data_out", 64'(hif.data_out), 64'd0);
    trst = 1'b1;
    @(negedge clk);

    // DR len 8, 0xA5, loopback: capture is data shifted up one bit -> 0x4A
    run_op(2'b00, 5'd8, 32'hA5, 2, -1, "dr8");
    check_run("dr8", 13, 64'h0C01, 64'h0528, 32'h4A);
    @(negedge clk);
    check("dr8_done_width", {62'd0, hif.done, hif.busy}, 64'd0);

    // IR len 4, TDO high; TLR issued in the clk cycle right after done
    run_op(2'b01, 5'd4, 32'h3, 1, -1, "ir4");
    check_run("ir4", 10, 64'h0183, 64'h0030, 32'hF);
    run_op(2'b10, 5'd0, 32'hDEAD, 0, -1, "tlr");
    check_run("tlr", 6, 64'h001F, 64'h0, 32'hF);

    // full 32-bit DR with len=0
    run_op(2'b00, 5'd0, 32'hFFFF_FFFF, 0, -1, "dr32");
    check_run("dr32", 37, 64'h0000_000C_0000_0001, 64'h0000_0007_FFFF_FFF8, 32'h0);

    // reserved op is ignored
    hif.op = 2'b11; hif.len = 5'd4; hif.data_in = 32'h1; hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (hif.busy || hif.done || tck || tms) bad++;
      @(negedge clk);
    end
    check("rsv_ignored", 64'(bad), 64'd0);

    // start pulsed mid-scan has no effect on the running DR
    run_op(2'b00, 5'd8, 32'h5A, 1, 15, "dr_midstart");
    check_run("dr_midstart", 13, 64'h0C01, 64'h02D0, 32'hFF);

    // TRST mid-scan aborts immediately with no done
    @(negedge clk);
    hif.op = 2'b00; hif.len = 5'd8; hif.data_in = 32'h33; hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_pre_busy", 64'(hif.busy), 64'd1);
    trst = 1'b0;
    #1;
    check("abort_pins", {61'd0, tck, tms, tdi}, 64'd0);
    check("abort_busy", {62'd0, hif.busy, hif.done}, 64'd0);
    check("abort_data_out", 64'(hif.data_out), 64'd0);
    repeat (3) @(negedge clk);
    trst = 1'b1;
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      if (hif.busy || hif.done || tck) bad++;
      @(negedge clk);
    end
    check("abort_quiet", 64'(bad), 64'd0);

    // resynchronise with TLR after reset
    run_op(2'b10, 5'd0, 32'h0, 0, -1, "tlr2");
    check_run("tlr2", 6, 64'h001F, 64'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, number of clk cycles per TCK half-period (legal range 1..255).
REQ-002 SHALL have parameter MAX_LEN, default 32, maximum scan length in bits.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 TRST  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request pulse; sampled only while busy=0.
REQ-006 op  input  2  00 DR scan, 01 IR scan, 10 TLR sequence, 11 reserved.
REQ-007 len  input  5  scan length; 1..31 = that many bits, 0 = 32 bits.
REQ-008 data_in  input  MAX_LEN  scan data, shifted out on TDI LSB first.
REQ-009 busy  output  1  high from the accepted start until done.
REQ-010 done  output  1  one-clk pulse at operation completion.
REQ-011 data_out  output  MAX_LEN  captured TDO bits, right-aligned, bit0 = first captured; upper bits zero.
REQ-012 TCK  output  1  generated test clock.
REQ-013 TMS  output  1  test mode select to target.
REQ-014 TDI  output  1  test data to target.
REQ-015 TDO  input  1  test data from target.

Function
REQ-016 SHALL hold TCK low, TMS=0 and TDI=0 whenever busy=0.
REQ-017 While busy, SHALL toggle TCK every CLK_DIV clk cycles, starting low; one TCK period = 2*CLK_DIV clk.
REQ-018 SHALL change TMS/TDI only in the clk cycle TCK goes 1->0, plus the initial values driven in the cycle busy rises (TCK low).
REQ-019 SHALL sample TDO in the clk cycle TCK goes 0->1 using its value before the edge, during shift bits only.
REQ-020 start with busy=0 and op in {00,01,10} SHALL latch op, len and data_in and raise busy on the next clk; op=11 SHALL be ignored (busy stays 0, no done).
REQ-021 start while busy=1 SHALL be ignored, with no effect on the running operation.
REQ-022 The controller assumes the target is in Run-Test/Idle at every accepted DR/IR start.
REQ-023 DR scan TMS per TCK rise: 1,0,0, then N shift rises (TMS 0 for the first N-1, 1 on the last), then 1, then 0; N+5 TCK periods total.
REQ-024 IR scan TMS per TCK rise: 1,1,0,0, then N shift rises as in REQ-023, then 1, then 0; N+6 TCK periods total.
REQ-025 TLR TMS per TCK rise: 1,1,1,1,1,0; 6 TCK periods total; data_out SHALL be unchanged.
REQ-026 TDI at shift rise k (k=0..N-1) SHALL equal data_in[k]; TDI SHALL be 0 on non-shift rises.
REQ-027 TDO sampled at shift rise k SHALL land in data_out[k]; bits N..MAX_LEN-1 SHALL be 0.
REQ-028 data_out SHALL update only at completion and hold until the next DR/IR completion.
REQ-029 Completion is the first TCK 1->0 transition after the final rise. In that clk cycle: done=1, busy->0, TMS=0, TCK=0.
REQ-030 A new start SHALL be accepted in the clk cycle after done.
REQ-031 FSM states: IDLE, PRE (Select/Capture path TMS), SHIFT, POST (Exit1/Update/RTI TMS), FINISH. A bit counter SHALL count shift rises 0..N-1.

Reset
REQ-032 TRST=0 SHALL immediately force: state IDLE, busy=0, done=0, TCK=0, TMS=0, TDI=0, data_out=0, and clear the divider and bit counters.
REQ-033 TRST asserted mid-operation SHALL abort the operation with no done pulse.
REQ-034 After TRST deasserts, the block SHALL wait in IDLE. The host issues op=10 to resynchronise the target.

Verification
REQ-035 CLK_DIV=2, start op=00 len=8 data_in=0xA5, TDO loopback of TDI delayed one TCK fall -> 13 TCK periods, busy high 52 clk, TDI shift bits 1,0,1,0,0,1,0,1, done pulse, data_out reflects the delayed stream.
REQ-036 op=01 len=4 data_in=0x3, TDO tied 1 -> TMS sequence 1,1,0,0,0,0,0,1,1,0 (10 periods), data_out=0x0000000F.
REQ-037 op=10 -> TMS 1,1,1,1,1,0, done after 6 TCK periods, data_out unchanged from its prior value.
REQ-038 op=00 len=0 data_in=0xFFFFFFFF, TDO tied 0 -> 32 shift rises with TDI=1, 37 periods, data_out=0.
REQ-039 start pulsed again mid-scan, then TRST pulsed low mid-scan -> second start ignored; after TRST, TCK/TMS/busy=0 immediately and no done pulse.
REQ-040 op=11 start -> busy stays 0, TCK idle, no done.
